// File: rtl/br_lite_local_ni.sv
// BrLite local network interface: buffers PE messages toward the router's
// local input (req/ack injection, throttled by local_busy) and buffers flits
// arriving from the router's local output for the PE.

package br_lite_pkg;
  localparam int unsigned BR_ID_W      = 8;
  localparam int unsigned BR_SVC_W     = 2;
  localparam int unsigned BR_PAYLOAD_W = 32;

  localparam logic [BR_SVC_W-1:0] BR_SVC_ALL    = 2'd0;
  localparam logic [BR_SVC_W-1:0] BR_SVC_TARGET = 2'd1;
  localparam logic [BR_SVC_W-1:0] BR_SVC_CLEAR  = 2'd2;

  typedef struct packed {
    logic [BR_SVC_W-1:0]     service;
    logic [BR_ID_W-1:0]      id;
    logic [15:0]             seq_source;
    logic [15:0]             seq_target;
    logic [BR_PAYLOAD_W-1:0] payload;
  } br_data_t;
endpackage

module br_lite_local_ni
  import br_lite_pkg::*;
#(
  parameter logic [15:0] SEQ_ADDRESS = 16'h0000,
  parameter int unsigned TX_DEPTH    = 4,
  parameter int unsigned RX_DEPTH    = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  // PE transmit side
  input  logic                    tx_valid_i,
  output logic                    tx_ready_o,
  input  logic [BR_SVC_W-1:0]     tx_service_i,
  input  logic [15:0]             tx_target_i,
  input  logic [BR_PAYLOAD_W-1:0] tx_payload_i,
  output logic                    tx_err_o,
  // PE receive side
  output logic                    rx_valid_o,
  input  logic                    rx_ready_i,
  output br_data_t                rx_flit_o,
  // router local port
  input  logic                    local_busy_i,
  output br_data_t                flit_o,
  output logic                    req_o,
  input  logic                    ack_i,
  input  br_data_t                flit_i,
  input  logic                    req_i,
  output logic                    ack_o
);

  localparam int unsigned TPW = (TX_DEPTH > 1) ? $clog2(TX_DEPTH) : 1;
  localparam int unsigned TCW = TPW + 1;
  localparam int unsigned RPW = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;
  localparam int unsigned RCW = RPW + 1;

  localparam logic [TPW-1:0]     TP_ONE  = TPW'(1);
  localparam logic [TCW-1:0]     TC_ONE  = TCW'(1);
  localparam logic [TCW-1:0]     TC_ZERO = TCW'(0);
  localparam logic [TCW-1:0]     TC_FULL = TCW'(TX_DEPTH);
  localparam logic [RPW-1:0]     RP_ONE  = RPW'(1);
  localparam logic [RCW-1:0]     RC_ONE  = RCW'(1);
  localparam logic [RCW-1:0]     RC_ZERO = RCW'(0);
  localparam logic [RCW-1:0]     RC_FULL = RCW'(RX_DEPTH);
  localparam logic [BR_ID_W-1:0] ID_ONE  = BR_ID_W'(1);

  typedef struct packed {
    logic [BR_SVC_W-1:0]     service;
    logic [15:0]             target;
    logic [BR_PAYLOAD_W-1:0] payload;
  } tx_entry_t;

  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_REQ  = 2'd1,
    TX_DROP = 2'd2,
    TX_WAIT = 2'd3
  } tx_state_e;

  typedef enum logic [1:0] {
    RX_IDLE = 2'd0,
    RX_ACK  = 2'd1,
    RX_WAIT = 2'd2
  } rx_state_e;

  // ---------------------------------------------------------------- TX side
  tx_entry_t          tx_mem_r [TX_DEPTH];
  logic [TPW-1:0]     tx_wr_ptr_r, tx_rd_ptr_r;
  logic [TCW-1:0]     tx_count_r, tx_count_next_s;
  logic               tx_ready_r, tx_err_r;
  logic               tx_accept_s, tx_push_s, tx_clear_s, tx_pop_s;
  tx_entry_t          tx_wdata_s, tx_head_s;
  tx_state_e          tx_state_r, tx_state_next_s;
  logic               req_r;
  br_data_t           flit_r, tx_flit_next_s;
  logic [BR_ID_W-1:0] tx_id_r;
  logic               tx_id_inc_s;

  // Classify a PE transfer: clear requests are swallowed and flagged
  always_comb begin
    tx_accept_s        = tx_valid_i && tx_ready_r;
    tx_clear_s         = 1'b0;
    tx_push_s          = 1'b0;
    tx_wdata_s.service = tx_service_i;
    tx_wdata_s.target  = tx_target_i;
    tx_wdata_s.payload = tx_payload_i;
    if (tx_accept_s) begin
      if (tx_service_i == BR_SVC_CLEAR) begin
        tx_clear_s = 1'b1;
      end else begin
        tx_push_s = 1'b1;
      end
    end else begin
      tx_clear_s = 1'b0;
      tx_push_s  = 1'b0;
    end
  end

  // Next TX occupancy from push/pop pair
  always_comb begin
    tx_count_next_s = tx_count_r;
    case ({tx_push_s, tx_pop_s})
      2'b10:   tx_count_next_s = tx_count_r + TC_ONE;
      2'b01:   tx_count_next_s = tx_count_r - TC_ONE;
      default: tx_count_next_s = tx_count_r;
    endcase
  end

  // TX FIFO pointers, occupancy, registered ready and error pulse
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tx_wr_ptr_r <= {TPW{1'b0}};
      tx_rd_ptr_r <= {TPW{1'b0}};
      tx_count_r  <= TC_ZERO;
      tx_ready_r  <= 1'b1;
      tx_err_r    <= 1'b0;
    end else begin
      if (tx_push_s) begin
        tx_wr_ptr_r <= tx_wr_ptr_r + TP_ONE;
      end
      if (tx_pop_s) begin
        tx_rd_ptr_r <= tx_rd_ptr_r + TP_ONE;
      end
      tx_count_r <= tx_count_next_s;
      tx_ready_r <= (tx_count_next_s != TC_FULL);
      tx_err_r   <= tx_clear_s;
    end
  end

  // TX FIFO storage (no reset needed, guarded by occupancy)
  always_ff @(posedge clk_i) begin
    if (tx_push_s) begin
      tx_mem_r[tx_wr_ptr_r] <= tx_wdata_s;
    end
  end

  // Stamp source address and id onto the FIFO head
  always_comb begin
    tx_head_s                 = tx_mem_r[tx_rd_ptr_r];
    tx_flit_next_s.service    = tx_head_s.service;
    tx_flit_next_s.id         = tx_id_r;
    tx_flit_next_s.seq_source = SEQ_ADDRESS;
    tx_flit_next_s.seq_target = tx_head_s.target;
    tx_flit_next_s.payload    = tx_head_s.payload;
  end

  // TX injection FSM: next state, FIFO pop and id advance
  always_comb begin
    tx_state_next_s = tx_state_r;
    tx_pop_s        = 1'b0;
    tx_id_inc_s     = 1'b0;
    case (tx_state_r)
      TX_IDLE: begin
        if ((tx_count_r != TC_ZERO) && !local_busy_i) begin
          tx_pop_s        = 1'b1;
          tx_state_next_s = TX_REQ;
        end else begin
          tx_state_next_s = TX_IDLE;
        end
      end
      TX_REQ: begin
        if (ack_i) begin
          tx_id_inc_s     = 1'b1;
          tx_state_next_s = TX_DROP;
        end else begin
          tx_state_next_s = TX_REQ;
        end
      end
      TX_DROP: tx_state_next_s = TX_WAIT;
      TX_WAIT: begin
        // the router's CAM entry for the last message is still live while busy
        if (local_busy_i) begin
          tx_state_next_s = TX_WAIT;
        end else begin
          tx_state_next_s = TX_IDLE;
        end
      end
      default: tx_state_next_s = TX_IDLE;
    endcase
  end

  // TX FSM state, registered req, latched flit and id counter
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tx_state_r <= TX_IDLE;
      req_r      <= 1'b0;
      flit_r     <= '0;
      tx_id_r    <= {BR_ID_W{1'b0}};
    end else begin
      tx_state_r <= tx_state_next_s;
      req_r      <= (tx_state_next_s == TX_REQ);
      if (tx_pop_s) begin
        flit_r <= tx_flit_next_s;
      end
      if (tx_id_inc_s) begin
        tx_id_r <= tx_id_r + ID_ONE;
      end
    end
  end

  assign tx_ready_o = tx_ready_r;
  assign tx_err_o   = tx_err_r;
  assign req_o      = req_r;
  assign flit_o     = flit_r;

  // ---------------------------------------------------------------- RX side
  br_data_t       rx_mem_r [RX_DEPTH];
  logic [RPW-1:0] rx_wr_ptr_r, rx_rd_ptr_r, rx_rd_ptr_next_s;
  logic [RCW-1:0] rx_count_r, rx_count_next_s;
  logic           rx_valid_r, rx_push_s, rx_pop_s;
  br_data_t       rx_flit_r, rx_flit_next_s;
  rx_state_e      rx_state_r, rx_state_next_s;
  logic           ack_r;

  // RX acceptance FSM; a flit is pushed during the single ack cycle
  always_comb begin
    rx_state_next_s = rx_state_r;
    case (rx_state_r)
      RX_IDLE: begin
        if (req_i && (rx_count_r != RC_FULL)) begin
          rx_state_next_s = RX_ACK;
        end else begin
          rx_state_next_s = RX_IDLE;
        end
      end
      RX_ACK:  rx_state_next_s = RX_WAIT;
      RX_WAIT: begin
        // wait for the router to drop req so one request is taken once
        if (req_i) begin
          rx_state_next_s = RX_WAIT;
        end else begin
          rx_state_next_s = RX_IDLE;
        end
      end
      default: rx_state_next_s = RX_IDLE;
    endcase
  end

  // RX FIFO next occupancy, read pointer and head value
  always_comb begin
    rx_push_s        = (rx_state_r == RX_ACK);
    rx_pop_s         = rx_valid_r && rx_ready_i;
    rx_count_next_s  = rx_count_r;
    rx_rd_ptr_next_s = rx_rd_ptr_r;
    rx_flit_next_s   = '0;
    case ({rx_push_s, rx_pop_s})
      2'b10:   rx_count_next_s = rx_count_r + RC_ONE;
      2'b01:   rx_count_next_s = rx_count_r - RC_ONE;
      default: rx_count_next_s = rx_count_r;
    endcase
    if (rx_pop_s) begin
      rx_rd_ptr_next_s = rx_rd_ptr_r + RP_ONE;
    end else begin
      rx_rd_ptr_next_s = rx_rd_ptr_r;
    end
    // the head slot may be the one written this cycle, so bypass flit_i
    if (rx_count_next_s == RC_ZERO) begin
      rx_flit_next_s = '0;
    end else if (rx_push_s && (rx_wr_ptr_r == rx_rd_ptr_next_s)) begin
      rx_flit_next_s = flit_i;
    end else begin
      rx_flit_next_s = rx_mem_r[rx_rd_ptr_next_s];
    end
  end

  // RX FSM state, registered ack, FIFO pointers and registered head
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_state_r  <= RX_IDLE;
      ack_r       <= 1'b0;
      rx_wr_ptr_r <= {RPW{1'b0}};
      rx_rd_ptr_r <= {RPW{1'b0}};
      rx_count_r  <= RC_ZERO;
      rx_valid_r  <= 1'b0;
      rx_flit_r   <= '0;
    end else begin
      rx_state_r <= rx_state_next_s;
      ack_r      <= (rx_state_next_s == RX_ACK);
      if (rx_push_s) begin
        rx_wr_ptr_r <= rx_wr_ptr_r + RP_ONE;
      end
      rx_rd_ptr_r <= rx_rd_ptr_next_s;
      rx_count_r  <= rx_count_next_s;
      rx_valid_r  <= (rx_count_next_s != RC_ZERO);
      rx_flit_r   <= rx_flit_next_s;
    end
  end

  // RX FIFO storage
  always_ff @(posedge clk_i) begin
    if (rx_push_s) begin
      rx_mem_r[rx_wr_ptr_r] <= flit_i;
    end
  end

  assign ack_o      = ack_r;
  assign rx_valid_o = rx_valid_r;
  assign rx_flit_o  = rx_flit_r;

endmodule

// File: doc/br_lite_local_ni.md
Name: br_lite_local_ni

Overview:
- Local network interface between a processing element (PE) and the local port of a BrLite broadcast router.
- TX path: queues PE messages, stamps seq_source and id, and injects them into the router local input using the router's req/ack protocol.
- TX path also throttles injection on the router's local_busy signal.
- RX path: accepts flits from the router's local output using the same req/ack protocol and buffers them for the PE.

Parameters:
- SEQ_ADDRESS, 16'h0000, sequential address of the attached router, stamped into seq_source.
- TX_DEPTH, 4, TX FIFO entries, power of 2, >= 2.
- RX_DEPTH, 4, RX FIFO entries, power of 2, >= 2.

Ports:
- clk_i  in  1  clock, all logic on rising edge.
- rst_i  in  1  asynchronous active-high reset.
- tx_valid_i  in  1  PE message valid.
- tx_ready_o  out  1  TX FIFO not full.
- tx_service_i  in  width of br_data_t.service  requested service (BR_SVC_ALL or target service).
- tx_target_i  in  16  seq_target.
- tx_payload_i  in  width of br_data_t.payload  payload.
- tx_err_o  out  1  one-cycle pulse when a BR_SVC_CLEAR request is dropped.
- rx_valid_o  out  1  RX FIFO not empty.
- rx_ready_i  in  1  PE pops the RX head.
- rx_flit_o  out  br_data_t  RX FIFO head.
- local_busy_i  in  1  router local_busy_o.
- flit_o / req_o / ack_i  out / out / in  br_data_t / 1 / 1  to router local input (flit_i, req_i, ack_o).
- flit_i / req_i / ack_o  in / in / out  br_data_t / 1 / 1  from router local output (flit_o, req_o, ack_i).

Behaviour:
- Reset values, all outputs: tx_ready_o=1, tx_err_o=0, rx_valid_o=0, req_o=0, ack_o=0, flit_o=0, rx_flit_o=0.
- Reset state: both FIFOs empty, id counter=0, TX FSM in TX_IDLE, RX FSM in RX_IDLE.
- Reset asserted mid-handshake aborts the handshake immediately: req_o and ack_o fall combinationally with reset.

TX FIFO write:
- Write when tx_valid_i && tx_ready_o.
- If tx_service_i==BR_SVC_CLEAR, the message is not written and tx_err_o pulses in the next cycle. tx_ready_o still governs the transfer.
- Full FIFO: tx_ready_o=0 and the write is ignored.
- Simultaneous push and pop on a full FIFO: the pop frees the slot next cycle; tx_ready_o stays registered from the occupancy count.

TX FSM:
- TX_IDLE: when the FIFO is non-empty and local_busy_i==0, latch the head into flit_o (seq_source=SEQ_ADDRESS, id=id counter, other fields from the FIFO), pop the FIFO, and go to TX_REQ.
- TX_REQ: req_o=1, flit_o stable. On ack_i=1: id counter += 1 (wraps modulo 2^idwidth) and go to TX_DROP.
- TX_DROP: req_o=0. Go to TX_WAIT next cycle.
- TX_WAIT: stay while local_busy_i==1; otherwise go to TX_IDLE.
- The router raises local_busy in its write cycle, before its ack. Consequently a new injection never starts while the previous message's CAM entry is live.
- A message ignored by the router as a duplicate (busy stays 0) releases after two cycles.
- Minimum spacing between req_o rising edges: ack latency + 3 cycles.

RX FSM:
- RX_IDLE: if req_i==1 and the RX FIFO is not full, go to RX_ACK. If the FIFO is full, stay (backpressure); the router holds req until acknowledged.
- RX_ACK: ack_o=1 for exactly one cycle, and flit_i is pushed into the RX FIFO in this same cycle. Then go to RX_WAIT.
- RX_WAIT: stay until req_i==0 (the router drops req the cycle after ack), then go to RX_IDLE. This prevents a single request being accepted twice.
- RX FIFO pop when rx_valid_o && rx_ready_i. Push and pop in the same cycle are both honoured.

Test Plan:
- Reset, then push {svc=ALL, tgt=5, payload=0xA5}; router model acks 4 cycles after req -> flit_o.seq_source=SEQ_ADDRESS, id=0; req_o high exactly 4 cycles; id counter becomes 1.
- Two back-to-back messages, with local_busy_i held high for 20 cycles after the first ack -> second req_o rises no earlier than 2 cycles after local_busy_i falls; second flit carries id=1.
- Push with service=BR_SVC_CLEAR -> tx_err_o pulses once, FIFO count unchanged, no req_o.
- Fill TX FIFO (TX_DEPTH + 1 pushes, router not acking) -> tx_ready_o=0 after TX_DEPTH+1 accepted (one in flight); the extra write is ignored.
- Router delivers 5 flits while rx_ready_i=0 and RX_DEPTH=4 -> 4 acks; fifth req_i held unacked; first pop produces one ack within 2 cycles; order preserved.
- Assert rst_i during TX_REQ and again during RX_ACK -> req_o=0 and ack_o=0 immediately, FIFOs empty, id counter=0.
